pc_fetch_controller: RTL and testbench

- Sequences the program counter and instruction fetch for the MIPS core. It replaces the free-running increment-by-one PC with a PC that advances only on a completed fetch.
- Fetches through a req/ack handshake with instruction memory and hands each instruction to the decode stage with a valid/ready handshake.
- Applies branch and jump redirects, and halts on command or on a memory timeout.
- PC is word-addressed: +1 per instruction.

---
 rtl/pc_ctrl_pkg.sv | 11 +
 rtl/pc_target_calc.sv | 14 +
 rtl/pc_fetch_controller.sv | 128 ++++++++++++
 tb/tb_pc_fetch_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths and state encoding for the fetch controller
package pc_ctrl_pkg;
  localparam int PC_W = 32;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    HALTED = 3'd3
  } state_e;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: branch/jump redirect target, jump wins over branch
module pc_target_calc
  import pc_ctrl_pkg::*;
(
  input  logic [PC_W-1:0] redir_base_i,
  input  logic [15:0]     br_offset_i,
  input  logic [25:0]     j_target_i,
  input  logic            j_en_i,
  output logic [PC_W-1:0] target_o
);
  logic [PC_W-1:0] seq;
  assign seq = redir_base_i + 32'd1;
  assign target_o = j_en_i ? {seq[31:26], j_target_i} : seq + {{16{br_offset_i[15]}}, br_offset_i};
endmodule

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: PC sequencing, imem req/ack fetch and decode valid/ready handoff
module pc_fetch_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int WAIT_LIMIT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] instr_pc,
  input  logic            br_en,
  input  logic [15:0]     br_offset,
  input  logic            j_en,
  input  logic [25:0]     j_target,
  input  logic [PC_W-1:0] redir_base,
  input  logic            halt,
  output logic            halted,
  output logic            fetch_err
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_q, pend_d, ipc_q, ipc_d, target;
  logic [31:0] iout_q, iout_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic drop_q, drop_d, hpend_q, hpend_d, err_q, err_d, redir;
  assign redir = br_en | j_en;
  pc_target_calc u_target (
    .redir_base_i(redir_base),
    .br_offset_i (br_offset),
    .j_target_i  (j_target),
    .j_en_i      (j_en),
    .target_o    (target)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      ipc_q   <= '0;
      iout_q  <= '0;
      wait_q  <= '0;
      drop_q  <= 1'b0;
      hpend_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ipc_q   <= ipc_d;
      iout_q  <= iout_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      hpend_q <= hpend_d;
      err_q   <= err_d;
    end
  end
  // halt > redirect > ack/ready; a halted fetch still waits for its ack before stopping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ipc_d   = ipc_q;
    iout_d  = iout_q;
    wait_d  = wait_q;
    drop_d  = drop_q;
    hpend_d = hpend_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = halt ? HALTED : FETCH;
      FETCH: begin
        if (imem_ack) begin
          wait_d = '0;
          if (halt || hpend_q) begin
            state_d = HALTED;
          end else if (redir || drop_q) begin
            pc_d    = redir ? target : pend_q;
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            iout_d  = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd1;
            state_d = HOLD;
          end
        end else if (wait_q == LIMIT) begin
          err_d   = 1'b1;
          state_d = HALTED;
        end else begin
          wait_d = wait_q + CNT_W'(1);
          if (halt) begin
            hpend_d = 1'b1;
          end else if (redir) begin
            pend_d = target;
            drop_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redir) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    imem_req    = state_q == FETCH;
    imem_addr   = pc_q;
    instr_valid = state_q == HOLD;
    halted      = state_q == HALTED;
    instr_out   = iout_q;
    instr_pc    = ipc_q;
    fetch_err   = err_q;
  end
endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller: directed vectors with hand-computed expectations
module tb_pc_fetch_controller;
  logic CLK, RST, imem_req, imem_ack, instr_valid, instr_ready;
  logic br_en, j_en, halt, halted, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr_out, instr_pc, redir_base;
  logic [15:0] br_offset;
  logic [25:0] j_target;
  int checks = 0;
  int errors = 0;

  pc_fetch_controller #(.RESET_PC(32'h0), .WAIT_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .br_en(br_en), .br_offset(br_offset), .j_en(j_en), .j_target(j_target), .redir_base(redir_base),
    .halt(halt), .halted(halted), .fetch_err(fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] d);
    imem_ack = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic accept;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic jump(input logic [31:0] base, input logic [25:0] tgt);
    j_en = 1'b1;
    redir_base = base;
    j_target = tgt;
    tick();
    j_en = 1'b0;
  endtask

  task automatic branch(input logic [31:0] base, input logic [15:0] off);
    br_en = 1'b1;
    redir_base = base;
    br_offset = off;
    tick();
    br_en = 1'b0;
  endtask

  initial begin
    RST = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    br_en = 1'b0; br_offset = '0; j_en = 1'b0; j_target = '0; redir_base = '0; halt = 1'b0;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    RST = 1'b0;
    tick();
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'd0);
    tick();
    tick();
    fetch(32'h2002_0005);
    chk("h0_valid", {31'd0, instr_valid}, 32'd1);
    chk("h0_out", instr_out, 32'h2002_0005);
    chk("h0_pc", instr_pc, 32'd0);
    chk("h0_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("h0_keep", {31'd0, instr_valid}, 32'd1);
    accept();
    chk("f1_addr", imem_addr, 32'd1);
    chk("f1_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h11); accept();
    fetch(32'h22); accept();
    fetch(32'h33); accept();
    fetch(32'h44);
    chk("h4_pc", instr_pc, 32'd4);
    branch(32'd4, 16'hFFFE);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_addr", imem_addr, 32'd3);
    fetch(32'h55);
    chk("h3_pc", instr_pc, 32'd3);
    br_en = 1'b1; br_offset = 16'h0100;
    jump(32'h1000_0000, 26'h000_0040);
    br_en = 1'b0;
    chk("jbr_addr", imem_addr, 32'h1000_0040);
    fetch(32'h66);
    jump(32'h0, 26'd7);
    chk("j7_addr", imem_addr, 32'd7);
    jump(32'h0, 26'h20);
    chk("drop_addr", imem_addr, 32'd7);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    tick();
    tick();
    fetch(32'hDEAD_BEEF);
    chk("drop_gap_req", {31'd0, imem_req}, 32'd0);
    chk("drop_gap_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("drop_next_req", {31'd0, imem_req}, 32'd1);
    chk("drop_next_addr", imem_addr, 32'h20);
    fetch(32'h77);
    chk("h20_pc", instr_pc, 32'h20);
    chk("h20_out", instr_out, 32'h77);
    branch(32'hFFFF_FFFD, 16'h0001);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    fetch(32'h88);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFF);
    accept();
    chk("wrap_next", imem_addr, 32'd0);
    fetch(32'h99);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hh_halted", {31'd0, halted}, 32'd1);
    chk("hh_valid", {31'd0, instr_valid}, 32'd0);
    chk("hh_req", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    chk("hh_stay_req", {31'd0, imem_req}, 32'd0);
    chk("hh_stay_halted", {31'd0, halted}, 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hf_req", {31'd0, imem_req}, 32'd1);
    chk("hf_halted", {31'd0, halted}, 32'd0);
    fetch(32'hAA);
    chk("hf_done", {31'd0, halted}, 32'd1);
    chk("hf_valid", {31'd0, instr_valid}, 32'd0);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("to_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    repeat (4) tick();
    chk("to_wait_req", {31'd0, imem_req}, 32'd1);
    chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("to_req_stay", {31'd0, imem_req}, 32'd0);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("to_clr_err", {31'd0, fetch_err}, 32'd0);
    chk("to_clr_halted", {31'd0, halted}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
